// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and APB-side signal bundle for the shared APB master
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PREADY;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESETn,
  apb_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, gnt, idx;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                found, timed_out;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  assign timed_out     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign bus.req_ready = (state_q == IDLE && found) ? (NUM_REQ'(1) << gnt) : '0;
  assign bus.busy      = state_q != IDLE;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  // first valid requester at or after ptr, wrapping; descending scan so the closest one wins
  always_comb begin
    gnt   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end
  // next-state and registered bus/response values
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (found) begin
        gnt_d     = gnt;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = bus.req_write[gnt];
        paddr_d   = bus.req_addr[int'(gnt) * ADDR_W +: ADDR_W];
        pwdata_d  = bus.req_wdata[int'(gnt) * DATA_W +: DATA_W];
        ptr_d     = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        state_d   = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: if (bus.PREADY || timed_out) begin
        psel_d             = 1'b0;
        penable_d          = 1'b0;
        rsp_valid_d[gnt_q] = 1'b1;
        rsp_err_d          = !bus.PREADY;
        rsp_rdata_d        = (bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
        cnt_d              = '0;
        state_d            = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset drops the bus immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized transfers against a transaction-level model
module tb_apb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b1;
  int tests = 0;
  int fails = 0;
  int m_ptr = 0;
  logic [AW-1:0] a[N];
  logic [DW-1:0] d[N];
  logic          w[N];
  apb_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
      bus.req_write[i]          = w[i];
    end
  endtask
  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      d[i] = $urandom;
      w[i] = 1'($urandom_range(0, 1));
    end
    drive_payload();
  endtask
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  // called at a negedge in IDLE; returns at the negedge of the response cycle
  task automatic txn(input logic [N-1:0] v, input int waits, input logic [DW-1:0] prd);
    int g, nacc;
    logic err, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, rd;
    g = pick(v);
    ea = a[g];
    ed = d[g];
    ew = w[g];
    bus.req_valid = v;
    #1;
    chk("req_ready_idle", bus.req_ready, N'(1) << g);
    chk("busy_idle", bus.busy, 0);
    @(negedge PCLK);
    bus.req_valid = N'($urandom);
    bus.PREADY = 1'($urandom_range(0, 1));
    scramble();
    #1;
    chk("setup_psel", bus.PSEL, 1);
    chk("setup_penable", bus.PENABLE, 0);
    chk("setup_paddr", bus.PADDR, ea);
    chk("setup_pwdata", bus.PWDATA, ed);
    chk("setup_pwrite", bus.PWRITE, ew);
    chk("setup_busy", bus.busy, 1);
    chk("setup_ready", bus.req_ready, 0);
    m_ptr = (g + 1) % N;
    err = waits >= TO;
    nacc = err ? TO : waits + 1;
    rd = '0;
    for (int k = 0; k < nacc; k++) begin
      @(negedge PCLK);
      rd = (k == waits) ? prd : DW'($urandom);
      bus.PRDATA = rd;
      bus.PREADY = (k == waits);
      bus.req_valid = N'($urandom);
      #1;
      chk("access_psel", bus.PSEL, 1);
      chk("access_penable", bus.PENABLE, 1);
      chk("access_rsp", bus.rsp_valid, 0);
      chk("access_ready", bus.req_ready, 0);
    end
    @(negedge PCLK);
    bus.req_valid = '0;
    #1;
    chk("rsp_valid", bus.rsp_valid, N'(1) << g);
    chk("rsp_err", bus.rsp_err, err);
    chk("rsp_rdata", bus.rsp_rdata, (err || ew) ? '0 : rd);
    chk("done_psel", bus.PSEL, 0);
    chk("done_penable", bus.PENABLE, 0);
    chk("hold_paddr", bus.PADDR, ea);
    chk("hold_pwdata", bus.PWDATA, ed);
    chk("done_busy", bus.busy, 0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.PRDATA = '0;
    bus.PREADY = 1'b0;
    scramble();
    #1 PRESETn = 1'b0;
    @(negedge PCLK);
    #1;
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    a[0] = 32'h10; d[0] = 32'h1234; w[0] = 1'b1;
    drive_payload();
    txn(4'b0001, 0, '0);
    a[2] = 32'h20; w[2] = 1'b0;
    drive_payload();
    txn(4'b0100, 3, 32'hCAFEF00D);
    txn(4'b1000, 0, DW'($urandom));
    for (int r = 0; r < 8; r++) txn(4'b1111, 0, DW'($urandom));
    w[1] = 1'b0;
    drive_payload();
    txn(4'b0010, 100, 32'hDEADBEEF);
    txn(4'b0100, 1, 32'h5A5A0001);
    w[3] = 1'b1;
    drive_payload();
    bus.req_valid = 4'b1000;
    #1;
    chk("rstx_ready", bus.req_ready, 4'b1000);
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    #1;
    chk("rstx_penable", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rstx_psel", bus.PSEL, 0);
    chk("rstx_penable0", bus.PENABLE, 0);
    chk("rstx_rsp", bus.rsp_valid, 0);
    chk("rstx_busy", bus.busy, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    m_ptr = 0;
    txn(4'b1010, 0, DW'($urandom));
    txn(4'b1000, 0, DW'($urandom));
    txn(4'b1000, 0, DW'($urandom));
    txn(4'b0010, 2, DW'($urandom));
    txn(4'b1111, 0, DW'($urandom));
    bus.req_valid = '0;
    #1;
    chk("idle_ready", bus.req_ready, 0);
    @(negedge PCLK);
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_psel", bus.PSEL, 0);
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, 15));
      txn(v, $urandom_range(0, 20), DW'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
